// File: rtl/maxpool2d_stream.sv
// maxpool2d_stream: streaming 2x2/stride-2 max pooling over a raster pixel stream; optional fused ReLU via MAXPOOL_RELU_EN
module maxpool2d_stream #(
  parameter int DATA_W   = 8,
  parameter int CHANNELS = 2,
  parameter int IMG_W    = 6,
  parameter int IMG_H    = 6
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [CHANNELS*DATA_W-1:0] in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CHANNELS*DATA_W-1:0] out_data,
  output logic                       out_last
);
  localparam int W   = CHANNELS * DATA_W;
  localparam int XW  = $clog2(IMG_W);
  localparam int YW  = $clog2(IMG_H);
  localparam int LW  = IMG_W / 2;
  localparam int LIW = LW > 1 ? $clog2(LW) : 1;
  logic [XW-1:0]  x;
  logic [YW-1:0]  y;
  logic [W-1:0]   hold, px, pair, quad;
  logic [W-1:0]   lb [LW];
  logic [LIW-1:0] li;
  logic           acc, x_end;
  assign in_ready = !clear && (!out_valid || out_ready);
  assign acc      = in_valid && in_ready;
  assign li       = LIW'(x >> 1);
  assign x_end    = x == XW'(IMG_W - 1);
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [DATA_W-1:0] h, p, l, m;
`ifdef MAXPOOL_RELU_EN
    assign px[c*DATA_W +: DATA_W] = in_data[c*DATA_W+DATA_W-1] ? '0 : in_data[c*DATA_W +: DATA_W];
`else
    assign px[c*DATA_W +: DATA_W] = in_data[c*DATA_W +: DATA_W];
`endif
    assign h = hold[c*DATA_W +: DATA_W];
    assign p = px[c*DATA_W +: DATA_W];
    assign l = lb[li][c*DATA_W +: DATA_W];
    assign m = h > p ? h : p;
    assign pair[c*DATA_W +: DATA_W] = m;
    assign quad[c*DATA_W +: DATA_W] = m > l ? m : l;
  end
  // raster counters, even-column hold register and registered pooled output
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      x         <= '0;
      y         <= '0;
      hold      <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else if (clear) begin
      x         <= '0;
      y         <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      if (acc) begin
        x <= x_end ? '0 : x + 1'b1;
        if (x_end) y <= y == YW'(IMG_H - 1) ? '0 : y + 1'b1;
        if (!x[0]) hold <= px;
      end
      if (acc && x[0] && y[0]) begin
        out_data  <= quad;
        out_valid <= 1'b1;
        out_last  <= x == XW'(2 * LW - 1) && y == YW'(2 * (IMG_H / 2) - 1);
      end else if (out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  // line buffer keeps the horizontal pair max of each even row for the row below
  always_ff @(posedge clk)
    if (acc && x[0] && !y[0]) lb[li] <= pair;
endmodule
